// File: rtl/universal_shift_register.sv
// Mode-selectable shift register: single-step shift/rotate/load/clear plus a
// counted burst engine that repeats one shift mode N times with busy/done.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_msb,
  input  logic             serial_in_lsb,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_amt,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out_lsb,
  output logic             serial_out_msb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SR   = 3'b001;
  localparam logic [2:0] MODE_SL   = 3'b010;
  localparam logic [2:0] MODE_RR   = 3'b011;
  localparam logic [2:0] MODE_RL   = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       burst_mode_q, burst_mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One register step for the given operation code.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             fill_msb,
    input logic             fill_lsb,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] res;
    case (op)
      MODE_HOLD: res = cur;
      MODE_SR:   res = {fill_msb, cur[WIDTH-1:1]};
      MODE_SL:   res = {cur[WIDTH-2:0], fill_lsb};
      MODE_RR:   res = {cur[0], cur[WIDTH-1:1]};
      MODE_RL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_LOAD: res = ld;
      MODE_CLR:  res = {WIDTH{1'b0}};
      default:   res = cur;
    endcase
    return res;
  endfunction

  // Only the five shift/rotate codes can be repeated by the burst engine.
  function automatic logic is_burst_mode(input logic [2:0] op);
    logic ok;
    case (op)
      MODE_SR, MODE_SL, MODE_RR, MODE_RL, MODE_ASR: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next-state, datapath and handshake decode.
  always_comb begin
    state_d      = state_q;
    burst_mode_d = burst_mode_q;
    count_d      = count_q;
    q_d          = q_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (start && is_burst_mode(mode)) begin
            burst_mode_d = mode;
            count_d      = shift_amt;
            if (shift_amt != CNT_ZERO) begin
              state_d = ST_BURST;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            q_d = step_fn(mode, q_q, serial_in_msb, serial_in_lsb, load_data);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        // Burst ignores mode/start/load_data; fills are still live each step.
        if (en) begin
          q_d     = step_fn(burst_mode_q, q_q, serial_in_msb, serial_in_lsb, load_data);
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    busy_d = (state_d == ST_BURST);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      burst_mode_q <= MODE_HOLD;
      count_q      <= CNT_ZERO;
      q_q          <= {WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_mode_q <= burst_mode_d;
      count_q      <= count_d;
      q_q          <= q_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign Q              = q_q;
  assign serial_out_lsb = q_q[0];
  assign serial_out_msb = q_q[WIDTH-1];
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register against an arithmetic
// reference model of the register, burst counter and done pulse.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [2:0]    mode;
  logic          smsb;
  logic          slsb;
  logic [W-1:0]  ld;
  logic          start;
  logic [CW-1:0] amt;
  logic [W-1:0]  Q;
  logic          so_lsb;
  logic          so_msb;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_q;
  int           m_left;
  int           m_bmode;
  logic         m_done;

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .serial_in_msb(smsb), .serial_in_lsb(slsb), .load_data(ld),
    .start(start), .shift_amt(amt), .Q(Q),
    .serial_out_lsb(so_lsb), .serial_out_msb(so_msb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [W-1:0] ref_step(int op, logic [W-1:0] q, logic fm, logic fl, logic [W-1:0] d);
    logic [W-1:0] top;
    logic signed [W-1:0] s;
    top = '0;
    top[W-1] = fm;
    s = q;
    case (op)
      1: return (q >> 1) | top;
      2: return (q << 1) | W'(fl);
      3: return (q >> 1) | (q << (W - 1));
      4: return (q << 1) | (q >> (W - 1));
      5: return s >>> 1;
      6: return d;
      7: return '0;
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    m_q = '0; m_left = 0; m_bmode = 0; m_done = 1'b0;
  endtask

  // Advance the model by one edge using current inputs, then the DUT clock.
  task automatic tick();
    logic nd;
    nd = 1'b0;
    if (en) begin
      if (m_left > 0) begin
        m_q = ref_step(m_bmode, m_q, smsb, slsb, ld);
        m_left--;
        if (m_left == 0) nd = 1'b1;
      end else if (start && mode >= 3'd1 && mode <= 3'd5) begin
        m_bmode = int'(mode);
        m_left  = int'(amt);
        if (m_left == 0) nd = 1'b1;
      end else begin
        m_q = ref_step(int'(mode), m_q, smsb, slsb, ld);
      end
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [W-1:0] v);
    en = 1'b1; start = 1'b0; mode = 3'd6; ld = v;
    tick();
    mode = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b0; mode = 3'd0; smsb = 1'b0; slsb = 1'b0;
    ld = '0; start = 1'b0; amt = '0;
    model_reset();
    #12;
    n_vec++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_state Q=%h busy=%b done=%b exp 00/0/0", Q, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    load(8'hA5);
    n_vec++;
    if (Q !== 8'hA5) begin n_err++; $display("FAIL load_a5 Q=%h exp a5", Q); end
    #2; reset = 1'b0; #1;
    model_reset();
    n_vec++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL async_reset Q=%h busy=%b done=%b exp 00/0/0", Q, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_step();
    logic [2:0] ops [5] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd7};
    logic [W-1:0] exp [5] = '{8'hC0, 8'h03, 8'hC0, 8'h02, 8'h00};
    logic [W-1:0] e;
    for (int i = 0; i < 5; i++) begin
      load(8'h81);
      mode = ops[i]; slsb = 1'b0; smsb = 1'($urandom_range(0, 1));
      tick();
      e = exp[i];
      n_vec++;
      if (Q !== e || Q !== m_q) begin
        n_err++; $display("FAIL step_mode%0d Q=%h exp %h model %h", ops[i], Q, e, m_q);
      end
      n_vec++;
      if (so_msb !== e[W-1] || so_lsb !== e[0]) begin
        n_err++; $display("FAIL step_serial_out%0d msb=%b lsb=%b exp %b %b", ops[i], so_msb, so_lsb, e[W-1], e[0]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 5) != 0);
      mode = 3'($urandom_range(0, 7));
      smsb = 1'($urandom_range(0, 1)); slsb = 1'($urandom_range(0, 1));
      ld = 8'($urandom);
      tick();
      n_vec++;
      if (Q !== m_q || busy !== 1'b0) begin
        n_err++; $display("FAIL step_random Q=%h busy=%b exp %h 0", Q, busy, m_q);
      end
    end
    en = 1'b1; mode = 3'd0;
  endtask

  task automatic test_burst();
    load(8'hF0);
    mode = 3'd1; start = 1'b1; amt = 4'd3; smsb = 1'b0;
    tick();
    start = 1'b0; mode = 3'($urandom_range(0, 7)); ld = 8'($urandom); amt = 4'($urandom);
    n_vec++;
    if (busy !== 1'b1 || Q !== 8'hF0) begin
      n_err++; $display("FAIL burst_start busy=%b Q=%h exp 1 f0", busy, Q);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) begin
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || Q !== m_q) begin
          n_err++; $display("FAIL burst_mid%0d busy=%b done=%b Q=%h exp 1 0 %h", k, busy, done, Q, m_q);
        end
      end
    end
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1 || Q !== 8'h1E || so_lsb !== 1'b0 || Q !== m_q) begin
      n_err++; $display("FAIL burst_end busy=%b done=%b Q=%h lsb=%b exp 0 1 1e 0", busy, done, Q, so_lsb);
    end
    mode = 3'd0;
    tick();
    n_vec++;
    if (done !== 1'b0 || Q !== 8'h1E) begin
      n_err++; $display("FAIL burst_done_clear done=%b Q=%h exp 0 1e", done, Q);
    end
  endtask

  task automatic test_burst_stall();
    int cnt;
    load(8'h81);
    mode = 3'd4; start = 1'b1; amt = 4'd4;
    tick();
    start = 1'b0; mode = 3'd0;
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 20 && busy; i++) begin
      en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      tick();
      if (busy) cnt++;
    end
    en = 1'b1;
    n_vec++;
    if (cnt !== 6 || Q !== 8'h18 || done !== 1'b1 || Q !== m_q) begin
      n_err++; $display("FAIL burst_stall busy_cycles=%0d Q=%h done=%b exp 6 18 1", cnt, Q, done);
    end
  endtask

  task automatic test_zero_amt();
    logic [W-1:0] v;
    v = 8'($urandom);
    load(v);
    mode = 3'd1; start = 1'b1; amt = 4'd0;
    tick();
    start = 1'b0; mode = 3'd0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b1 || Q !== v) begin
      n_err++; $display("FAIL zero_amt busy=%b done=%b Q=%h exp 0 1 %h", busy, done, Q, v);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== v) begin
      n_err++; $display("FAIL zero_amt_after busy=%b done=%b Q=%h exp 0 0 %h", busy, done, Q, v);
    end
  endtask

  task automatic test_rr_wrap();
    int cnt;
    load(8'h01);
    mode = 3'd3; start = 1'b1; amt = 4'd9;
    tick();
    start = 1'b0; mode = 3'd0;
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 20 && busy; i++) begin
      tick();
      if (busy) cnt++;
    end
    n_vec++;
    if (cnt !== 9 || Q !== 8'h80 || done !== 1'b1 || Q !== m_q) begin
      n_err++; $display("FAIL rr_wrap busy_cycles=%0d Q=%h done=%b exp 9 80 1", cnt, Q, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    load(8'($urandom));
    mode = 3'd1; start = 1'b1; amt = 4'd6;
    tick();
    start = 1'b0; mode = 3'd0;
    tick(); tick();
    #2; reset = 1'b0; #1;
    model_reset();
    n_vec++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_burst_reset Q=%h busy=%b done=%b exp 00 0 0", Q, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL abort_no_done cyc%0d done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    load(8'hA3);
    mode = 3'd1; start = 1'b1; amt = 4'd2; smsb = 1'b1;
    tick();
    start = 1'b0; mode = 3'd0;
    tick(); tick();
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || Q !== 8'hE8) begin
      n_err++; $display("FAIL b2b_first done=%b busy=%b Q=%h exp 1 0 e8", done, busy, Q);
    end
    mode = 3'd4; start = 1'b1; amt = 4'd3;
    tick();
    start = 1'b0; mode = 3'd0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept busy=%b done=%b exp 1 0", busy, done);
    end
    for (int i = 0; i < 10 && busy; i++) tick();
    n_vec++;
    if (Q !== 8'h47 || done !== 1'b1 || Q !== m_q) begin
      n_err++; $display("FAIL b2b_second Q=%h done=%b exp 47 1", Q, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 3) == 0);
      mode  = 3'($urandom_range(0, 7));
      amt   = 4'($urandom_range(0, 11));
      smsb  = 1'($urandom_range(0, 1));
      slsb  = 1'($urandom_range(0, 1));
      ld    = 8'($urandom);
      tick();
      n_vec++;
      if (Q !== m_q || busy !== (m_left > 0) || done !== m_done ||
          so_lsb !== m_q[0] || so_msb !== m_q[W-1]) begin
        n_err++;
        $display("FAIL random cyc%0d Q=%h busy=%b done=%b exp %h %b %b", i, Q, busy, done, m_q, (m_left > 0), m_done);
      end
    end
    en = 1'b1; start = 1'b0; mode = 3'd0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst();
    test_burst_stall();
    test_zero_amt();
    test_rr_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised, mode-selectable shift register that extends the basic 8-bit right-shift register with several additions: configurable width, left/right/rotate/arithmetic shifting, parallel load and clear, serial taps at both ends, and a multi-step burst engine with busy/done handshake. It sits on the serial datapath between input capture and the display/bit-stream logic. It replaces fixed-width shift chains wherever a load-then-serialise or shift-by-N operation is needed.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH)+1, width of burst shift count
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- en  input  1  clock enable; when low, register, counter and FSM hold (done still clears)
- mode  input  3  operation select (see Operation)
- serial_in_msb  input  1  fill bit entering Q[WIDTH-1] on right shift
- serial_in_lsb  input  1  fill bit entering Q[0] on left shift
- load_data  input  WIDTH  parallel load value
- start  input  1  burst request, sampled in IDLE
- shift_amt  input  CNT_W  burst step count, sampled with start
- Q  output  WIDTH  register contents
- serial_out_lsb  output  1  Q[0], combinational
- serial_out_msb  output  1  Q[WIDTH-1], combinational
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse after a burst completes

## Operation
- Mode codes, one step:
  - 000 hold
  - 001 SR: Q <= {serial_in_msb, Q[W-1:1]}
  - 010 SL: Q <= {Q[W-2:0], serial_in_lsb}
  - 011 RR: Q <= {Q[0], Q[W-1:1]}
  - 100 RL: Q <= {Q[W-2:0], Q[W-1]}
  - 101 ASR: Q <= {Q[W-1], Q[W-1:1]}
  - 110 load: Q <= load_data
  - 111 clear: Q <= 0
- FSM states: IDLE, BURST.
- IDLE, en=1, start=0: apply one step of mode at each edge.
- IDLE, en=1, start=1, mode ∈ {001..101}:
  - Latch mode into burst_mode and shift_amt into count. No step at this edge.
  - count≠0: go to BURST.
  - count=0: stay in IDLE, pulse done.
- start with mode ∈ {000,110,111}: start is ignored and the mode executes as a single step.
- BURST, en=1: apply one step of burst_mode and decrement count.
  - On the edge where count goes 1→0: return to IDLE and set done.
- BURST: mode, start, shift_amt and load_data are ignored. Serial fill inputs are still sampled every step.
- BURST, en=0: stall with no step; count and state hold.
- shift_amt may exceed WIDTH; all steps are executed (rotates wrap; SR/SL fully flush to fill bits).

## Timing
- Reset (async, any time): Q=0, busy=0, done=0, state=IDLE, count=0.
  - Reset mid-burst aborts the burst; no done is produced.
- Single-step modes: Q updates at the first enabled edge. Latency 1.
- busy = (state==BURST), registered. It rises at the start edge and falls at the final-step edge.
- Burst of N≥1 steps with en held high: steps occur at edges 1..N after the start edge. busy is high for exactly N cycles.
- done:
  - Registered, high for exactly one cycle following the final-step edge, and cleared at the next edge regardless of en.
  - For N=0, done is high in the cycle after the start edge.
- A new start is accepted in the same cycle that done is high (back-to-back bursts, no bubble).
- serial_out_* track Q with zero added latency.

## Test plan
- Reset/async: load 8'hA5, assert reset between edges -> Q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Single-step modes, WIDTH=8, Q=8'b1000_0001:
  - RR -> 8'b1100_0000
  - RL -> 8'b0000_0011
  - ASR -> 8'b1100_0000
  - SL with serial_in_lsb=0 -> 8'b0000_0010
  - clear -> 0
- Burst: load 8'hF0, start, mode=SR, shift_amt=3, serial_in_msb=0 -> busy high 3 cycles, Q=8'h1E, done high 1 cycle, serial_out_lsb=0.
- Burst with stall: RL burst, shift_amt=4, on 8'h81, en low for 2 cycles mid-burst -> busy high 6 cycles, final Q=8'h18.
- Edge cases:
  - shift_amt=0 -> no Q change, busy never high, done pulse next cycle.
  - RR with shift_amt=9 on 8'h01 -> Q=8'h80.
  - Reset asserted during a burst -> no done.
- Back-to-back: second start issued in the done cycle -> accepted, with busy low for exactly that one cycle.
